// File: rtl/vpm_pkg.sv
// Shared types and helpers for the VPM valid/ready pipeline chain.
// Sizing functions let each chain derive its widths from its own parameters.
package vpm_pkg;

    localparam int VPM_MAX_DEPTH  = 16;
    localparam int VPM_DATA_WIDTH = 8;
    localparam int VPM_CTRL_WIDTH = 1;

    function automatic int vpm_payload_width(input int data_width, input int ctrl_width);
        return data_width + ctrl_width;
    endfunction

    localparam int VPM_PAYLOAD_WIDTH = vpm_payload_width(VPM_DATA_WIDTH, VPM_CTRL_WIDTH);

    // Default-width payload; chains with other widths declare the same shape locally.
    typedef struct packed {
        logic [VPM_DATA_WIDTH-1:0] data;
        logic [VPM_CTRL_WIDTH-1:0] ctrl;
    } vpm_payload_t;

    function automatic int vpm_occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vpm_pipe_stage.sv
// One valid/ready pipeline stage: a register slot with bubble collapsing and
// flush, or a pure combinational pass-through when BYPASS is set.
module vpm_pipe_stage #(
    parameter int WIDTH  = 9,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_payload,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_payload,
    output logic             valid_next
);

    if (BYPASS) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk, rst, flush_n};

        assign dn_valid   = up_valid;
        assign up_ready   = dn_ready;
        assign dn_payload = up_payload;
        assign valid_next = 1'b0;
    end else begin : g_reg
        logic             valid_q;
        logic [WIDTH-1:0] payload_q;

        // An empty slot always accepts, so bubbles collapse under a stall.
        assign up_ready   = !valid_q || dn_ready;
        assign valid_next = flush_n && (up_ready ? up_valid : valid_q);

        // NOTE: non-blocking assignments make every stage sample pre-edge values,
        // so a word moves exactly one slot per clock.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q   <= 1'b0;
                // NOTE: the payload is reset as well so out_data reads 0 until the first word.
                payload_q <= '0;
            end else begin
                valid_q <= valid_next;
                if (up_ready && up_valid) begin
                    payload_q <= up_payload;
                end
            end
        end

        assign dn_valid   = valid_q;
        assign dn_payload = payload_q;
    end

endmodule

// File: rtl/vpm_pipe_chain.sv
// Parametrised DEPTH-stage valid/ready chain carrying data plus a control
// sideband, with per-stage flush/bypass and a registered occupancy count.
module vpm_pipe_chain
    import vpm_pkg::*;
#(
    parameter int               DATA_WIDTH  = 8,
    parameter int               CTRL_WIDTH  = 1,
    parameter int               DEPTH       = 4,
    parameter logic [DEPTH-1:0] BYPASS_MASK = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic [CTRL_WIDTH-1:0]             in_ctrl,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    input  logic [DEPTH-1:0]                  flush_n,
    output logic [vpm_occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = vpm_occ_width(DEPTH);

    if (DEPTH < 1 || DEPTH > VPM_MAX_DEPTH) begin : g_depth_check
        $error("vpm_pipe_chain: DEPTH must be within 1..16");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CTRL_WIDTH-1:0] ctrl;
    } payload_t;

    // Index i is the input side of stage i; index DEPTH is the chain output.
    logic [DEPTH:0]   valid_w;
    logic [DEPTH:0]   ready_w;
    payload_t         payload_w [DEPTH+1];
    logic [DEPTH-1:0] valid_next;
    logic [OCC_W-1:0] occ_next;

    assign valid_w[0]     = in_valid;
    assign payload_w[0]   = '{data: in_data, ctrl: in_ctrl};
    assign in_ready       = ready_w[0];
    assign ready_w[DEPTH] = out_ready;
    assign out_valid      = valid_w[DEPTH];
    assign out_data       = payload_w[DEPTH].data;
    assign out_ctrl       = payload_w[DEPTH].ctrl;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        vpm_pipe_stage #(
            .WIDTH  ($bits(payload_t)),
            .BYPASS (BYPASS_MASK[i])
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush_n    (flush_n[i]),
            .up_valid   (valid_w[i]),
            .up_ready   (ready_w[i]),
            .up_payload (payload_w[i]),
            .dn_valid   (valid_w[i+1]),
            .dn_ready   (ready_w[i+1]),
            .dn_payload (payload_w[i+1]),
            .valid_next (valid_next[i])
        );
    end

    // Counting next-state valids keeps the registered count in step with the slots.
    always_comb begin
        // NOTE: default assignment first so this block can never infer a latch.
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OCC_W'(valid_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

endmodule
